i2c_rom_sequencer: RTL and testbench

- Controller that sequences the byte-level I2C engine through a full LCD refresh.
- Sends one command transaction that streams cmd ROM bytes, then one data transaction that streams lcd ROM bytes.
- Owns the shared ROM address bus and the cmd/lcd select. Retries a phase on NACK and reports done/error to the system.

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_byte_port.sv | 54 +++++
 rtl/i2c_rom_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_i2c_rom_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings and default constants for the I2C ROM sequencer and its byte port.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_DEV   = 4'd1,
    S_CTL   = 4'd2,
    S_FETCH = 4'd3,
    S_DATA  = 4'd4,
    S_WAIT  = 4'd5,
    S_ABORT = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_e;

  typedef enum logic {
    PH_CMD = 1'b0,
    PH_LCD = 1'b1
  } phase_e;

  // Which kind of byte is outstanding, so WAIT knows where to branch.
  typedef enum logic [1:0] {
    K_DEV  = 2'd0,
    K_CTL  = 2'd1,
    K_DATA = 2'd2
  } byte_kind_e;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h3C;
  localparam logic [7:0] CTL_CMD_DEF  = 8'h00;
  localparam logic [7:0] CTL_DATA_DEF = 8'h40;

  function automatic logic [7:0] addr_write_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_byte_port.sv
// Holds one outstanding byte toward the I2C engine; the FSM loads it and sees ack/nack
// in the cycle the engine reports completion.
module i2c_byte_port (
  input  logic       ck,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       start,
  input  logic       stop,
  output logic       ack,
  output logic       nack,
  output logic       xfer_req,
  output logic [7:0] xfer_data,
  output logic       xfer_start,
  output logic       xfer_stop,
  input  logic       xfer_done,
  input  logic       xfer_nack
);

  logic       req_r;
  logic [7:0] data_r;
  logic       start_r;
  logic       stop_r;

  // A done pulse only counts while a byte is actually outstanding.
  assign ack  = req_r & xfer_done;
  assign nack = ack & xfer_nack;

  // Byte latch: fields stay frozen while req is high and clear once the engine finishes.
  always_ff @(posedge ck) begin
    if (reset) begin
      req_r   <= 1'b0;
      data_r  <= 8'h00;
      start_r <= 1'b0;
      stop_r  <= 1'b0;
    end else if (load) begin
      req_r   <= 1'b1;
      data_r  <= data;
      start_r <= start;
      stop_r  <= stop;
    end else if (ack) begin
      req_r   <= 1'b0;
      data_r  <= 8'h00;
      start_r <= 1'b0;
      stop_r  <= 1'b0;
    end
  end

  assign xfer_req   = req_r;
  assign xfer_data  = data_r;
  assign xfer_start = start_r;
  assign xfer_stop  = stop_r;

endmodule

// File: rtl/i2c_rom_sequencer.sv
// Drives the byte-level I2C engine through a command transaction then a data transaction,
// streaming both ROMs and restarting a phase on NACK until the retry budget is spent.
module i2c_rom_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF,
  parameter int         CMD_LEN   = 10,
  parameter int         LCD_LEN   = 1024,
  parameter logic [7:0] CTL_CMD   = CTL_CMD_DEF,
  parameter logic [7:0] CTL_DATA  = CTL_DATA_DEF,
  parameter int         MAX_RETRY = 3
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       go,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [9:0] rom_addr,
  output logic       rom_sel,
  input  logic [7:0] rom_data,
  output logic       xfer_req,
  output logic [7:0] xfer_data,
  output logic       xfer_start,
  output logic       xfer_stop,
  input  logic       xfer_done,
  input  logic       xfer_nack
);

  localparam logic [9:0] CMD_LAST  = 10'(CMD_LEN - 1);
  localparam logic [9:0] LCD_LAST  = 10'(LCD_LEN - 1);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

  state_e     state_r, state_nx_s;
  phase_e     phase_r;
  byte_kind_e kind_r;
  logic [9:0] idx_r, idx_nx_s, addr_r;
  logic [7:0] retry_r, byte_r, tx_s;
  logic       busy_r, done_r, error_r, sel_r;
  logic       last_s, accept_s, ack_s, nack_s, load_s, start_s, stop_s;

  assign last_s   = (phase_r == PH_LCD) ? (idx_r == LCD_LAST) : (idx_r == CMD_LAST);
  assign accept_s = (state_r == S_IDLE) && go;

  // State register.
  always_ff @(posedge ck) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and next-index selection.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (go) begin
          state_nx_s = S_DEV;
          idx_nx_s   = 10'd0;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_DEV, S_CTL, S_DATA: state_nx_s = S_WAIT;
      S_FETCH:              state_nx_s = S_DATA;
      S_WAIT: begin
        if (!ack_s) begin
          state_nx_s = S_WAIT;
        end else if (nack_s) begin
          if (retry_r < RETRY_MAX) begin
            state_nx_s = S_ABORT;
            idx_nx_s   = 10'd0;
          end else begin
            state_nx_s = S_ERROR;
          end
        end else begin
          case (kind_r)
            K_DEV: state_nx_s = S_CTL;
            K_CTL: state_nx_s = S_FETCH;
            K_DATA: begin
              if (!last_s) begin
                state_nx_s = S_FETCH;
                idx_nx_s   = idx_r + 10'd1;
              end else if (phase_r == PH_CMD) begin
                state_nx_s = S_DEV;
                idx_nx_s   = 10'd0;
              end else begin
                state_nx_s = S_DONE;
              end
            end
            default: state_nx_s = S_ERROR;
          endcase
        end
      end
      S_ABORT:         state_nx_s = S_DEV;
      S_DONE, S_ERROR: state_nx_s = S_IDLE;
      default:         state_nx_s = S_IDLE;
    endcase
  end

  // Byte-port load strobe and the fields of the byte being issued.
  always_comb begin
    load_s  = 1'b0;
    tx_s    = 8'h00;
    start_s = 1'b0;
    stop_s  = 1'b0;
    case (state_r)
      S_DEV: begin
        load_s  = 1'b1;
        tx_s    = addr_write_byte(DEV_ADDR);
        start_s = 1'b1;
      end
      S_CTL: begin
        load_s = 1'b1;
        tx_s   = (phase_r == PH_LCD) ? CTL_DATA : CTL_CMD;
      end
      S_DATA: begin
        load_s = 1'b1;
        tx_s   = byte_r;
        stop_s = last_s;
      end
      default: load_s = 1'b0;
    endcase
  end

  // Phase, index, retry, ROM address and status registers.
  always_ff @(posedge ck) begin
    if (reset) begin
      phase_r <= PH_CMD;
      kind_r  <= K_DEV;
      idx_r   <= 10'd0;
      retry_r <= 8'd0;
      byte_r  <= 8'h00;
      addr_r  <= 10'd0;
      sel_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      idx_r  <= idx_nx_s;
      done_r <= (state_nx_s == S_DONE);
      if (accept_s) begin
        busy_r  <= 1'b1;
        error_r <= 1'b0;
        phase_r <= PH_CMD;
        retry_r <= 8'd0;
      end else if (state_nx_s == S_DONE || state_nx_s == S_ERROR) begin
        busy_r  <= 1'b0;
        error_r <= (state_nx_s == S_ERROR);
      end else if (state_nx_s == S_ABORT) begin
        retry_r <= retry_r + 8'd1;
      end else if (state_r == S_WAIT && state_nx_s == S_DEV) begin
        // Only a completed command phase goes straight from WAIT to DEV.
        phase_r <= PH_LCD;
        retry_r <= 8'd0;
      end
      if (state_nx_s == S_FETCH) begin
        addr_r <= idx_nx_s;
        sel_r  <= phase_r;
      end
      if (state_r == S_FETCH) begin
        byte_r <= rom_data;
      end
      case (state_r)
        S_DEV:   kind_r <= K_DEV;
        S_CTL:   kind_r <= K_CTL;
        S_DATA:  kind_r <= K_DATA;
        default: kind_r <= kind_r;
      endcase
    end
  end

  i2c_byte_port u_port (
    .ck         (ck),
    .reset      (reset),
    .load       (load_s),
    .data       (tx_s),
    .start      (start_s),
    .stop       (stop_s),
    .ack        (ack_s),
    .nack       (nack_s),
    .xfer_req   (xfer_req),
    .xfer_data  (xfer_data),
    .xfer_start (xfer_start),
    .xfer_stop  (xfer_stop),
    .xfer_done  (xfer_done),
    .xfer_nack  (xfer_nack)
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign rom_addr = addr_r;
  assign rom_sel  = sel_r;

endmodule

// File: tb/tb_i2c_rom_sequencer.sv
// Scoreboard bench: an engine model checks every issued byte against queued expectations.
module tb_i2c_rom_sequencer;

  localparam int CMD_LEN   = 3;
  localparam int LCD_LEN   = 4;
  localparam int MAX_RETRY = 2;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic [7:0] data;
    logic       chk;
    logic       sel;
    logic [9:0] addr;
  } beat_t;

  logic       ck = 1'b0;
  logic       reset, go;
  logic       busy, done, error, rom_sel;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic       xfer_req, xfer_start, xfer_stop, xfer_done, xfer_nack;
  logic [7:0] xfer_data;

  beat_t exp_q[$];
  int    n_pass = 0, n_total = 0, hs_bad = 0, nbytes = 0, nack_at = -1;
  int    lat_lo = 1, lat_hi = 1;
  bit    nack_addr = 1'b0;

  always #5 ck = ~ck;

  function automatic logic [7:0] cmd_rom(input logic [9:0] a);
    return 8'hC0 ^ a[7:0];
  endfunction

  function automatic logic [7:0] lcd_rom(input logic [9:0] a);
    return 8'hA0 + a[7:0];
  endfunction

  assign rom_data = rom_sel ? lcd_rom(rom_addr) : cmd_rom(rom_addr);

  i2c_rom_sequencer #(
    .DEV_ADDR(7'h3C), .CMD_LEN(CMD_LEN), .LCD_LEN(LCD_LEN),
    .CTL_CMD(8'h00), .CTL_DATA(8'h40), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .ck(ck), .reset(reset), .go(go), .busy(busy), .done(done), .error(error),
    .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
    .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_start(xfer_start),
    .xfer_stop(xfer_stop), .xfer_done(xfer_done), .xfer_nack(xfer_nack)
  );

  // Engine model + scoreboard: each new byte is popped against the expectation queue.
  initial begin : engine
    beat_t      e;
    logic [9:0] cur;
    int         lat, k, here;
    xfer_done = 1'b0;
    xfer_nack = 1'b0;
    forever begin
      @(negedge ck);
      if (xfer_done) begin
        xfer_done = 1'b0;
        xfer_nack = 1'b0;
        if (xfer_req !== 1'b0) hs_bad++;
      end else if (xfer_req === 1'b1 && reset === 1'b0) begin
        cur  = {xfer_start, xfer_stop, xfer_data};
        here = nbytes;
        nbytes++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_extra: got byte %h start=%b stop=%b, want no byte", xfer_data, xfer_start, xfer_stop);
        end else begin
          e = exp_q.pop_front();
          if (cur !== {e.start, e.stop, e.data} || (e.chk && {rom_sel, rom_addr} !== {e.sel, e.addr}))
            $display("FAIL sb_byte #%0d: got %h s=%b p=%b sel=%b addr=%0d, want %h s=%b p=%b sel=%b addr=%0d",
                     here, xfer_data, xfer_start, xfer_stop, rom_sel, rom_addr,
                     e.data, e.start, e.stop, e.sel, e.addr);
          else
            n_pass++;
        end
        lat = $urandom_range(lat_hi, lat_lo);
        k = 1;
        while (k < lat && xfer_req === 1'b1) begin
          @(negedge ck);
          k++;
          if (xfer_req === 1'b1 && {xfer_start, xfer_stop, xfer_data} !== cur) hs_bad++;
        end
        if (xfer_req === 1'b1 && reset === 1'b0) begin
          xfer_done = 1'b1;
          xfer_nack = (nack_addr && cur[9]) || (here == nack_at);
        end
      end
    end
  end

  task automatic push_exp(input logic s, input logic p, input logic [7:0] d,
                          input logic chk, input logic sel, input logic [9:0] a);
    beat_t b;
    b.start = s; b.stop = p; b.data = d; b.chk = chk; b.sel = sel; b.addr = a;
    exp_q.push_back(b);
  endtask

  // Address byte, control byte, then the first n ROM bytes of one phase.
  task automatic push_phase(input bit lcd, input int n);
    int len;
    len = lcd ? LCD_LEN : CMD_LEN;
    push_exp(1'b1, 1'b0, 8'h78, 1'b0, 1'b0, 10'd0);
    push_exp(1'b0, 1'b0, lcd ? 8'h40 : 8'h00, 1'b0, 1'b0, 10'd0);
    for (int i = 0; i < n; i++)
      push_exp(1'b0, (i == len - 1), lcd ? lcd_rom(10'(i)) : cmd_rom(10'(i)), 1'b1, lcd, 10'(i));
  endtask

  task automatic push_refresh;
    push_phase(1'b0, CMD_LEN);
    push_phase(1'b1, LCD_LEN);
  endtask

  task automatic pulse_go;
    @(negedge ck);
    go = 1'b1;
  endtask

  task automatic wait_end(input int budget, input bit go_at_done, output bit ended,
                          output int dones, output logic busy_at_done, output logic err_end);
    ended = 1'b0; dones = 0; busy_at_done = 1'bx; err_end = 1'bx;
    for (int c = 0; c < budget && !ended; c++) begin
      @(negedge ck);
      go = (done === 1'b1) && go_at_done;
      if (done === 1'b1) begin
        dones++;
        busy_at_done = busy;
      end
      if (busy === 1'b0) begin
        ended   = 1'b1;
        err_end = error;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; go = 1'b0;
    repeat (3) @(negedge ck);
    n_total++;
    if ({busy, done, error, rom_sel, xfer_req, xfer_start, xfer_stop} !== 7'd0)
      $display("FAIL reset_ctl: got %b, want 0000000", {busy, done, error, rom_sel, xfer_req, xfer_start, xfer_stop});
    else n_pass++;
    n_total++;
    if (rom_addr !== 10'd0) $display("FAIL reset_addr: got %0d, want 0", rom_addr); else n_pass++;
    n_total++;
    if (xfer_data !== 8'h00) $display("FAIL reset_data: got %h, want 00", xfer_data); else n_pass++;
    reset = 1'b0;
    @(negedge ck);
  endtask

  task automatic test_nominal;
    bit ended; int dones, extra; logic bad, err;
    lat_lo = 1; lat_hi = 3;
    push_refresh();
    pulse_go();
    wait_end(3000, 1'b0, ended, dones, bad, err);
    n_total++;
    if (!ended) $display("FAIL nominal_timeout: got busy still high, want end"); else n_pass++;
    n_total++;
    if (dones !== 1) $display("FAIL nominal_done: got %0d pulses, want 1", dones); else n_pass++;
    n_total++;
    if (bad !== 1'b0) $display("FAIL nominal_busy_at_done: got %b, want 0", bad); else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL nominal_error: got %b, want 0", err); else n_pass++;
    extra = 0;
    repeat (5) begin
      @(negedge ck);
      if (done === 1'b1) extra++;
    end
    n_total++;
    if (extra !== 0 || exp_q.size() !== 0)
      $display("FAIL nominal_tail: got %0d extra done, %0d bytes left, want 0/0", extra, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_nack_retry;
    bit ended; int dones; logic bad, err;
    lat_lo = 1; lat_hi = 4;
    nack_at = nbytes + 8;
    push_phase(1'b0, CMD_LEN);
    push_phase(1'b1, 2);
    push_phase(1'b1, LCD_LEN);
    pulse_go();
    wait_end(3000, 1'b0, ended, dones, bad, err);
    nack_at = -1;
    n_total++;
    if (!ended || dones !== 1) $display("FAIL retry_done: got ended=%b done=%0d, want 1/1", ended, dones); else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL retry_error: got %b, want 0", err); else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL retry_left: got %0d bytes left, want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_retry_exhaust;
    bit ended; int dones; logic bad, err;
    lat_lo = 1; lat_hi = 3;
    nack_addr = 1'b1;
    repeat (MAX_RETRY + 1) push_exp(1'b1, 1'b0, 8'h78, 1'b0, 1'b0, 10'd0);
    pulse_go();
    wait_end(3000, 1'b0, ended, dones, bad, err);
    n_total++;
    if (!ended || dones !== 0) $display("FAIL exhaust_done: got ended=%b done=%0d, want 1/0", ended, dones); else n_pass++;
    n_total++;
    if (err !== 1'b1) $display("FAIL exhaust_error: got %b, want 1", err); else n_pass++;
    repeat (3) @(negedge ck);
    nack_addr = 1'b0;
    n_total++;
    if (exp_q.size() !== 0 || busy !== 1'b0 || error !== 1'b1)
      $display("FAIL exhaust_attempts: got left=%0d busy=%b error=%b, want 0/0/1", exp_q.size(), busy, error);
    else n_pass++;
    push_refresh();
    pulse_go();
    @(negedge ck);
    go = 1'b0;
    n_total++;
    if ({error, busy} !== 2'b01) $display("FAIL exhaust_clear: got error,busy=%b, want 01", {error, busy}); else n_pass++;
    wait_end(3000, 1'b0, ended, dones, bad, err);
    n_total++;
    if (dones !== 1 || exp_q.size() !== 0)
      $display("FAIL exhaust_rerun: got done=%0d left=%0d, want 1/0", dones, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_go_while_busy;
    bit ended; int dones, idle_bad; logic bad, err;
    lat_lo = 2; lat_hi = 5;
    push_refresh();
    pulse_go();
    @(negedge ck); go = 1'b0;
    repeat (6) @(negedge ck);
    go = 1'b1;
    @(negedge ck); go = 1'b0;
    wait_end(3000, 1'b1, ended, dones, bad, err);
    @(negedge ck); go = 1'b0;
    n_total++;
    if (dones !== 1 || bad !== 1'b0) $display("FAIL busy_go_done: got done=%0d busy=%b, want 1/0", dones, bad); else n_pass++;
    idle_bad = 0;
    repeat (20) begin
      @(negedge ck);
      if (busy !== 1'b0 || xfer_req !== 1'b0) idle_bad++;
    end
    n_total++;
    if (idle_bad !== 0 || exp_q.size() !== 0)
      $display("FAIL busy_go_restart: got %0d active cycles, %0d left, want 0/0", idle_bad, exp_q.size());
    else n_pass++;
    push_refresh();
    pulse_go();
    wait_end(3000, 1'b0, ended, dones, bad, err);
    n_total++;
    if (dones !== 1 || exp_q.size() !== 0)
      $display("FAIL busy_go_fresh: got done=%0d left=%0d, want 1/0", dones, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit ended, hit; int dones, base; logic bad, err;
    lat_lo = 20; lat_hi = 20;
    push_phase(1'b0, 1);
    base = nbytes;
    pulse_go();
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge ck);
      go = 1'b0;
      if (nbytes - base >= 3) hit = 1'b1;
    end
    n_total++;
    if (!hit) $display("FAIL midreset_reach: got %0d bytes, want 3", nbytes - base); else n_pass++;
    @(negedge ck);
    reset = 1'b1;
    @(negedge ck);
    n_total++;
    if ({busy, done, error, rom_sel, xfer_req, xfer_start, xfer_stop, xfer_data, rom_addr} !== 25'd0)
      $display("FAIL midreset_outs: got req=%b busy=%b data=%h addr=%0d, want all 0", xfer_req, busy, xfer_data, rom_addr);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge ck);
    n_total++;
    if (busy !== 1'b0 || xfer_req !== 1'b0 || exp_q.size() !== 0)
      $display("FAIL midreset_idle: got busy=%b req=%b left=%0d, want 0/0/0", busy, xfer_req, exp_q.size());
    else n_pass++;
    lat_lo = 1; lat_hi = 2;
    push_refresh();
    pulse_go();
    wait_end(3000, 1'b0, ended, dones, bad, err);
    n_total++;
    if (dones !== 1 || exp_q.size() !== 0)
      $display("FAIL midreset_rerun: got done=%0d left=%0d, want 1/0", dones, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_handshake;
    bit ended; int dones; logic bad, err;
    lat_lo = 1; lat_hi = 20;
    push_refresh();
    pulse_go();
    wait_end(6000, 1'b0, ended, dones, bad, err);
    n_total++;
    if (!ended || dones !== 1) $display("FAIL hs_done: got ended=%b done=%0d, want 1/1", ended, dones); else n_pass++;
    n_total++;
    if (hs_bad !== 0) $display("FAIL hs_stable: got %0d handshake violations, want 0", hs_bad); else n_pass++;
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL hs_left: got %0d bytes left, want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    test_reset();
    test_nominal();
    test_nack_retry();
    test_retry_exhaust();
    test_go_while_busy();
    test_reset_mid();
    test_handshake();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
